sysbus_mem_responder: RTL and testbench

// Memory-side responder for the Sysbus request/response protocol. It accepts
// 64-byte burst reads (instruction/data fetch) and burst writes from one

---
 rtl/sysbus_mem_responder.sv | 176 +++++++++++++++++
 tb/tb_sysbus_mem_responder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sysbus_mem_responder.sv
// ---------------------------------------------------------------------------
// sysbus_mem_responder
// Memory-side responder for the Sysbus request/response protocol. Serves
// 64-byte (8 x 64-bit) burst reads and burst writes from a single initiator,
// backed by an internal word array. Used as the simulation memory model and
// as the protocol reference for the cache/memory controller.
//
// Ports
//   clk          in   clock
//   reset        in   synchronous, active-low reset
//   bus_reqcyc   in   request valid (address beat or write-data beat)
//   bus_req      in   address (address phase) / write data (data phase)
//   bus_reqtag   in   {rw, device[3:0], id[7:0]}; rw=1 read, rw=0 write
//   bus_reqack   out  request/beat accepted this cycle (combinational)
//   bus_respcyc  out  read-data beat valid
//   bus_resp     out  read-data beat
//   bus_resptag  out  tag of the transaction being answered
//   bus_respack  in   initiator consumed the current beat
// ---------------------------------------------------------------------------

`ifndef SYSBUS_MEMORY
`define SYSBUS_MEMORY 4'h1
`endif

module sysbus_mem_responder #(
    parameter int unsigned BUS_DATA_WIDTH = 64,
    parameter int unsigned BUS_TAG_WIDTH  = 13,
    parameter int unsigned MEM_WORDS      = 4096,
    parameter int unsigned BURST_LEN      = 8,
    parameter int unsigned RESP_DELAY     = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_reqack,
    output logic                      bus_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    input  logic                      bus_respack
);

    // Word index width, line offset (8 words per 64-byte line) and counters
    localparam int unsigned IDX_W   = $clog2(MEM_WORDS);
    localparam int unsigned LINE_W  = 3;
    localparam int unsigned BEAT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int unsigned DLY_W   = (RESP_DELAY > 1) ? $clog2(RESP_DELAY) : 1;
    localparam int unsigned RW_BIT  = BUS_TAG_WIDTH - 1;
    localparam int unsigned DEV_LSB = 8;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [DLY_W-1:0]  LAST_DLY  = DLY_W'((RESP_DELAY > 0) ? (RESP_DELAY - 1) : 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RDELAY = 2'd1,
        RDATA  = 2'd2,
        WDATA  = 2'd3
    } state_t;

    state_t                     state_q;
    logic [BEAT_W-1:0]          beat_q;
    logic [DLY_W-1:0]           dly_q;
    logic [IDX_W-1:0]           base_q;
    logic [BUS_TAG_WIDTH-1:0]   tag_q;

    logic [BUS_DATA_WIDTH-1:0]  mem [MEM_WORDS];

    logic                       dev_match_c;
    logic [IDX_W-1:0]           addr_base_c;
    logic [IDX_W-1:0]           cur_idx_c;
    logic [IDX_W-1:0]           nxt_idx_c;
    logic [BEAT_W-1:0]          beat_inc_c;
    logic                       wr_en_c;

    // Request decode: device match, line-aligned base word index (wraps modulo MEM_WORDS)
    always_comb begin
        dev_match_c = (bus_reqtag[DEV_LSB +: 4] == `SYSBUS_MEMORY);
        addr_base_c = {bus_req[IDX_W+2 : LINE_W+3], LINE_W'(0)};
        beat_inc_c  = beat_q + BEAT_W'(1);
        cur_idx_c   = base_q + IDX_W'(beat_q);
        nxt_idx_c   = base_q + IDX_W'(beat_inc_c);
    end

    // Accept: address beats only in IDLE for our device, data beats in WDATA
    always_comb begin
        bus_reqack = 1'b0;
        if (state_q == IDLE)
            bus_reqack = bus_reqcyc && dev_match_c;
        else if (state_q == WDATA)
            bus_reqack = bus_reqcyc;
    end

    // A reset edge during a write burst must not commit the beat on the bus
    assign wr_en_c = reset && (state_q == WDATA) && bus_reqcyc;

    // Array write port (contents survive reset)
    always_ff @(posedge clk) begin
        if (wr_en_c)
            mem[cur_idx_c] <= bus_req;
    end

    // Transaction FSM with registered response outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            dly_q       <= '0;
            base_q      <= '0;
            tag_q       <= '0;
            bus_respcyc <= 1'b0;
            bus_resp    <= '0;
            bus_resptag <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    beat_q <= '0;
                    dly_q  <= '0;
                    if (bus_reqack) begin
                        tag_q  <= bus_reqtag;
                        base_q <= addr_base_c;
                        if (!bus_reqtag[RW_BIT])
                            state_q <= WDATA;
                        else if (RESP_DELAY == 0)
                            state_q <= RDATA;
                        else
                            state_q <= RDELAY;
                    end
                end

                RDELAY: begin
                    if (dly_q == LAST_DLY) begin
                        dly_q   <= '0;
                        state_q <= RDATA;
                    end else begin
                        dly_q <= dly_q + DLY_W'(1);
                    end
                end

                // First RDATA cycle loads beat 0; thereafter one beat per acked edge
                RDATA: begin
                    if (!bus_respcyc) begin
                        bus_respcyc <= 1'b1;
                        bus_resp    <= mem[cur_idx_c];
                        bus_resptag <= tag_q;
                    end else if (bus_respack) begin
                        if (beat_q == LAST_BEAT) begin
                            bus_respcyc <= 1'b0;
                            beat_q      <= '0;
                            state_q     <= IDLE;
                        end else begin
                            beat_q   <= beat_inc_c;
                            bus_resp <= mem[nxt_idx_c];
                        end
                    end
                end

                // Bubbles (reqcyc low) hold the beat counter
                WDATA: begin
                    if (bus_reqcyc) begin
                        if (beat_q == LAST_BEAT) begin
                            beat_q  <= '0;
                            state_q <= IDLE;
                        end else begin
                            beat_q <= beat_inc_c;
                        end
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_sysbus_mem_responder
// Directed bench for sysbus_mem_responder (default parameters, RESP_DELAY=2).
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
// ---------------------------------------------------------------------------
module tb_sysbus_mem_responder;

    logic        clk;
    logic        reset;
    logic        bus_reqcyc;
    logic [63:0] bus_req;
    logic [12:0] bus_reqtag;
    logic        bus_reqack;
    logic        bus_respcyc;
    logic [63:0] bus_resp;
    logic [12:0] bus_resptag;
    logic        bus_respack;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] exp_line [8];
    logic [63:0] exp_a    [8];
    logic [63:0] exp_b    [8];

    sysbus_mem_responder dut (
        .clk         (clk),
        .reset       (reset),
        .bus_reqcyc  (bus_reqcyc),
        .bus_req     (bus_req),
        .bus_reqtag  (bus_reqtag),
        .bus_reqack  (bus_reqack),
        .bus_respcyc (bus_respcyc),
        .bus_resp    (bus_resp),
        .bus_resptag (bus_resptag),
        .bus_respack (bus_respack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Write burst: address beat, 8 data beats, optional single bubble after beat bubble_after
    task automatic write_burst(input logic [63:0] addr, input logic [63:0] data [8],
                               input int bubble_after);
        int acks;
        acks       = 0;
        bus_reqcyc = 1'b1;
        bus_req    = addr;
        bus_reqtag = 13'h0102;
        #1;
        check("wr_addr_ack", bus_reqack, 1);
        cycle();
        for (int b = 0; b < 8; b++) begin
            bus_reqcyc = 1'b1;
            bus_req    = data[b];
            #1;
            if (bus_reqack) acks++;
            check("wr_no_respcyc", bus_respcyc, 0);
            cycle();
            if (b == bubble_after) begin
                bus_reqcyc = 1'b0;
                #1;
                check("wr_bubble_ack", bus_reqack, 0);
                cycle();
            end
        end
        bus_reqcyc = 1'b0;
        check("wr_beat_acks", 64'(acks), 8);
    endtask

    // Read burst with optional stall, reset abort, and a request held during the burst
    task automatic read_burst(input logic [63:0] addr, input logic [12:0] tag,
                              input logic [63:0] exp [8], input int stall_beat,
                              input int stall_n, input int abort_beat, input bit hold_req);
        bus_reqcyc  = 1'b1;
        bus_req     = addr;
        bus_reqtag  = tag;
        bus_respack = 1'b1;
        #1;
        check("rd_addr_ack", bus_reqack, 1);
        cycle();
        if (!hold_req) bus_reqcyc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rd_delay_respcyc", bus_respcyc, 0);
            if (hold_req) check("rd_delay_stall_ack", bus_reqack, 0);
            cycle();
        end
        for (int b = 0; b < 8; b++) begin
            if (b == stall_beat) begin
                bus_respack = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    check("rd_stall_respcyc", bus_respcyc, 1);
                    check("rd_stall_data", bus_resp, exp[b]);
                    cycle();
                end
            end
            bus_respack = 1'b1;
            check("rd_respcyc", bus_respcyc, 1);
            check("rd_data", bus_resp, exp[b]);
            check("rd_resptag", bus_resptag, 64'(tag));
            if (hold_req) check("rd_stall_ack", bus_reqack, 0);
            if (b == abort_beat) begin
                reset = 1'b0;
                cycle();
                check("abort_respcyc", bus_respcyc, 0);
                check("abort_resp", bus_resp, 0);
                check("abort_resptag", bus_resptag, 0);
                cycle();
                cycle();
                reset       = 1'b1;
                bus_respack = 1'b0;
                return;
            end
            cycle();
        end
        check("rd_end_respcyc", bus_respcyc, 0);
        bus_respack = 1'b0;
    endtask

    initial begin
        for (int b = 0; b < 8; b++) begin
            exp_line[b] = 64'((b + 1) * 17);
            exp_a[b]    = 64'(8'hA0 + b);
            exp_b[b]    = 64'(8'hB0 + b);
        end

        reset       = 1'b0;
        bus_reqcyc  = 1'b0;
        bus_req     = '0;
        bus_reqtag  = '0;
        bus_respack = 1'b0;
        cycle();
        cycle();
        check("rst_respcyc", bus_respcyc, 0);
        check("rst_resp", bus_resp, 0);
        check("rst_resptag", bus_resptag, 0);
        check("rst_reqack", bus_reqack, 0);
        reset = 1'b1;
        cycle();

        // Preload words 8..15 with 0x11..0x88, then read line 0x40
        write_burst(64'h40, exp_line, -1);
        read_burst(64'h40, 13'h1100, exp_line, -1, 0, -1, 1'b0);

        // Unaligned address in the same line, stall 5 cycles on beat 2
        read_burst(64'h7C, 13'h1107, exp_line, 2, 5, -1, 1'b0);

        // Write with a bubble after beat 3, read it back
        write_burst(64'h1000, exp_a, 3);
        read_burst(64'h1000, 13'h1123, exp_a, -1, 0, -1, 1'b0);

        // 0x8000 wraps to word 0
        write_burst(64'h0, exp_b, -1);
        read_burst(64'h8000, 13'h1131, exp_b, -1, 0, -1, 1'b0);

        // Foreign device: never acked, no response
        bus_reqcyc = 1'b1;
        bus_req    = 64'h40;
        bus_reqtag = 13'h1200;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("foreign_reqack", bus_reqack, 0);
            cycle();
            check("foreign_respcyc", bus_respcyc, 0);
        end
        bus_reqcyc = 1'b0;

        // Reset during beat 3, then a full read starts from beat 0
        read_burst(64'h40, 13'h1140, exp_line, -1, 0, 3, 1'b0);
        check("post_abort_respcyc", bus_respcyc, 0);
        read_burst(64'h40, 13'h1141, exp_line, -1, 0, -1, 1'b0);

        // Request held through a burst is stalled, then accepted in IDLE
        read_burst(64'h1000, 13'h1150, exp_a, 4, 2, -1, 1'b1);
        check("held_req_ack_idle", bus_reqack, 1);
        read_burst(64'h1000, 13'h1150, exp_a, -1, 0, -1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
